// File: rtl/xor_rr_arbiter.sv
// xor_rr_arbiter: shares one WIDTH-bit XOR unit between N_REQ requesters.
// Round-robin grant in IDLE, registered result held in HOLD until the
// downstream consumer takes it. One result per two cycles at best.
module xor_rr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         txn_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_reg;
    logic [ID_W-1:0]  last_grant_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic             rsp_valid_reg;
    logic [CNT_W-1:0] txn_count_reg;

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_valid;
    logic [N_REQ-1:0] search_vec;
    logic [N_REQ-1:0] grant_onehot;
    logic [WIDTH-1:0] xor_arr [N_REQ];
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             accept;

    // Per-requester XOR result and "above the pointer" priority mask.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign xor_arr[gi]    = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
            assign upper_mask[gi] = (ID_W'(gi) > last_grant_reg);
        end
    endgenerate

    assign upper_valid = req_valid & upper_mask;
    // Requesters after the pointer win first; otherwise wrap to the lowest index.
    assign search_vec  = (|upper_valid) ? upper_valid : req_valid;
    assign grant_found = |req_valid;

    // Lowest set bit of the search vector is the round-robin winner.
    always_comb begin
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (search_vec[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
    assign accept       = (state_reg == ST_IDLE) && grant_found;

    // Ready is suppressed while reset is asserted, even before the first edge.
    assign req_ready = (rst_n && accept) ? grant_onehot : '0;

    // Control path: state, priority pointer and completed-transaction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= ID_W'(N_REQ - 1);
            txn_count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant_reg <= grant_idx;
                        state_reg      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        txn_count_reg <= txn_count_reg + CNT_W'(1);
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Result channel: capture operands only on the grant edge, hold until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= xor_arr[grant_idx];
            rsp_id_reg    <= grant_idx;
        end else if ((state_reg == ST_HOLD) && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg == ST_HOLD);
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// tb_xor_rr_arbiter: directed checks of grant order, latency, stall,
// reset recovery and counter wrap (counter narrowed to 4 bits).
module tb_xor_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;
    logic [CNT_W-1:0]       txn_count;

    int tests = 0;
    int fails = 0;

    xor_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    logic [7:0] exp_rr_data [5] = '{8'hFF, 8'hEF, 8'hDF, 8'hCF, 8'hFF};
    int         exp_fair_id [3] = '{3, 0, 1};
    int         exp_cnt;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset: outputs cleared, ready forced low even with all valids up
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_txn_count", 32'(txn_count), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request, no stall
        req_valid      = 4'b0001;
        req_a[7:0]     = 8'hA5;
        req_b[7:0]     = 8'h3C;
        rsp_ready      = 1'b1;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data",  32'(rsp_data),  32'h99);
        check("t1_rsp_id",    32'(rsp_id),    32'h0);
        check("t1_busy",      32'(busy),      32'h1);
        tick();
        check("t1_valid_drop", 32'(rsp_valid), 32'h0);
        check("t1_txn_count",  32'(txn_count), 32'h1);
        check("t1_data_kept",  32'(rsp_data),  32'h99);

        // Round robin with all four valid, starting from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 8'(16 * i);
            req_b[i*WIDTH +: WIDTH] = 8'hFF;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("t2_id_%0d", k),    32'(rsp_id),    32'(k % 4));
            check($sformatf("t2_data_%0d", k),  32'(rsp_data),  32'(exp_rr_data[k]));
            check($sformatf("t2_hold_rdy_%0d", k), 32'(req_ready), 32'h0);
            tick();
            exp_cnt++;
            check($sformatf("t2_cnt_%0d", k),   32'(txn_count), 32'(exp_cnt));
        end

        // Back-pressure: requester 2 only, result held for 5 stalled cycles
        req_valid                = 4'b0100;
        req_a[2*WIDTH +: WIDTH]  = 8'h5A;
        req_b[2*WIDTH +: WIDTH]  = 8'h0F;
        rsp_ready                = 1'b0;
        #1;
        check("t3_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_a[2*WIDTH +: WIDTH] = 8'hFF;
        #1;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t3_valid_%0d", s), 32'(rsp_valid), 32'h1);
            check($sformatf("t3_data_%0d", s),  32'(rsp_data),  32'h55);
            check($sformatf("t3_id_%0d", s),    32'(rsp_id),    32'h2);
            check($sformatf("t3_ready_%0d", s), 32'(req_ready), 32'h0);
            if (s < 4) tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        exp_cnt++;
        check("t3_valid_drop", 32'(rsp_valid), 32'h0);
        check("t3_txn_count",  32'(txn_count), 32'(exp_cnt));

        // Fairness: last grant was 2, requesters 0,1,3 valid
        req_valid = 4'b1011;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_ready_%0d", k), 32'(req_ready), 32'(1 << exp_fair_id[k]));
            tick();
            check($sformatf("t4_id_%0d", k),    32'(rsp_id),    32'(exp_fair_id[k]));
            tick();
            exp_cnt++;
        end
        check("t4_txn_count", 32'(txn_count), 32'(exp_cnt));
        req_valid = '0;

        // Reset while a result is stalled
        req_valid   = 4'b0001;
        req_a[7:0]  = 8'h12;
        req_b[7:0]  = 8'h34;
        rsp_ready   = 1'b0;
        tick();
        req_valid = '0;
        #1;
        check("t5_pre_valid", 32'(rsp_valid), 32'h1);
        check("t5_pre_data",  32'(rsp_data),  32'h26);
        rst_n = 1'b0;
        tick();
        check("t5_valid", 32'(rsp_valid), 32'h0);
        check("t5_data",  32'(rsp_data),  32'h0);
        check("t5_cnt",   32'(txn_count), 32'h0);
        check("t5_busy",  32'(busy),      32'h0);
        rst_n     = 1'b1;
        req_valid = 4'hF;
        #1;
        check("t5_ready_after", 32'(req_ready), 32'h1);
        tick();
        check("t5_id_after",   32'(rsp_id),   32'h0);
        check("t5_data_after", 32'(rsp_data), 32'h26);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();

        // Counter wrap on a 4-bit counter: 17 transactions from zero
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            tick();
            check($sformatf("t6_cnt_%0d", n), 32'(txn_count), 32'(n % 16));
        end
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
